// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes, decoder constants and
// the multiply/divide unit state encoding, plus operand-signedness helpers.
// Ports: none (package).
package rv32_pkg;

  // OP-class opcode and the funct7 that selects the M extension.
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // RV32M funct3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // muldiv_unit state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or
// restoring divide on operand magnitudes, followed by a sign-fix cycle.
// Ports: clk/rst_n; start+funct3+rs1+rs2 request (sampled in IDLE only);
// busy (CALC/FIX), done (one-cycle pulse), result (held until next completion).
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [2:0]         f3_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   ma;      // multiplicand / dividend (shifted out MSB-first)
  logic [WIDTH-1:0]   mb;      // multiplier (shifted out LSB-first) / divisor
  logic [2*WIDTH-1:0] acc;     // product, or quotient in the low half
  logic [WIDTH-1:0]   rem;     // partial remainder, always < divisor
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result_q;

  // ---------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;

  assign a_neg    = op_rs1_signed(funct3) & rs1[WIDTH-1];
  assign b_neg    = op_rs2_signed(funct3) & rs2[WIDTH-1];
  assign a_mag    = a_neg ? ('0 - rs1) : rs1;
  assign b_mag    = b_neg ? ('0 - rs2) : rs2;
  assign div_zero = (rs2 == '0);
  // Signed overflow only exists for DIV/REM (funct3[0]==0 among divides).
  assign div_ovf  = ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
  assign special  = funct3[2] & (div_zero | div_ovf);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? rs1 : '1;
    end else begin
      special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // ---------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;

  // Multiply: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right one place.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mb[0] ? {1'b0, ma} : '0);

  // Divide: bring in the next dividend bit to form the 33-bit trial value.
  // When its top bit is set it already exceeds the divisor, so the
  // difference always fits back into WIDTH bits.
  assign div_shift = {rem, ma[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mb});
  assign div_sub   = div_shift[WIDTH-1:0] - mb;

  // ---------------------------------------------------------------
  // Sign fix-up and output selection
  // ---------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? ('0 - acc) : acc;
    quot_fix = (sign_a ^ sign_b) ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = sign_a ? ('0 - rem) : rem;
    case (f3_q)
      F3_MUL:                       fix_res = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      f3_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q   <= funct3;
            sign_a <= a_neg;
            sign_b <= b_neg;
            ma     <= a_mag;
            mb     <= b_mag;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            if (special) begin
              result_q <= special_res;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (f3_q[2]) begin
            rem             <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
            ma              <= ma << 1;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            mb  <= mb >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_res;
          state    <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state == S_CALC) || (state == S_FIX);
  assign done   = (state == S_DONE);
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit beside the ALU in the RV32I core. Consumes the register file read data (RD1 as rs1, RD2 as rs2) and produces a 32-bit result for the register file write port (WD3, with WE3 driven on done). The core stalls PC and instruction fetch while busy is high. One operation is in flight at a time: 33-cycle shift-add multiply or restoring divide, with a 1-cycle path for divide special cases.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  WIDTH  operand A (from RD1)
rs2  input  WIDTH  operand B (from RD2)
busy  output  1  high in CALC and FIX
done  output  1  single-cycle completion pulse, high in DONE
result  output  WIDTH  registered result; holds until the next completion

Behaviour:
- States: IDLE, CALC, FIX, DONE. All state is cleared asynchronously on !rst_n: state=IDLE, busy=0, done=0, result=0, counter=0, datapath registers=0.
- IDLE + start (edge E0):
  - Latch funct3 and the operand signs.
  - Latch operand magnitudes. rs1 is signed for MULH, MULHSU, DIV, REM. rs2 is signed for MULH, DIV, REM. All other operands are unsigned.
  - Clear the 64-bit accumulator and counter, then go to CALC.
- Divide special cases at E0 bypass CALC and go straight to DONE with result loaded, so done is high in the cycle after E0 (latency 1):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle, counter 0 to 31. On the edge where counter==31, go to FIX (32 iterations).
  - Multiply: shift-add on magnitudes into the 64-bit product.
  - Divide: restoring, 33-bit partial remainder, one quotient bit per cycle, MSB first.
- FIX (one cycle):
  - Negate the 64-bit product if the operand signs differ (signed ops only).
  - Negate the quotient if the dividend and divisor signs differ.
  - Give the remainder the sign of the dividend.
  - Select the output: MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register result and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. start in DONE is ignored; the core re-issues it after done.
- Normal latency: start edge E0, done high in the cycle following E33. busy is high from the cycle after E0 through the cycle after E32.
- start while busy or done is ignored, and operand changes during CALC/FIX have no effect (operands are latched).
- Reset mid-operation aborts the op immediately: no done pulse, result=0.
- Arithmetic is modulo 2^32 / 2^64. No exceptions are raised.

Decomposition:
- Shared package rv32_pkg:
  - funct3 localparams for the M-extension ops (F3_MUL ... F3_REMU).
  - OPCODE_OP (0110011) and FUNCT7_MULDIV (0000001) for the decoder.
  - The 2-bit state encoding.
- A single module. No sub-module is needed; the multiply and divide paths share the accumulator and counter.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; done high exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 20/0xFFFFFFFA -> 0xFFFFFFFD. REM same operands -> 2. DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF. REMU -> 0xF.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REMU -> 0x1234, done 1 cycle after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done 1 cycle after start.
- start pulsed again at cycle 10 of a divide with different operands -> ignored; original result delivered at cycle 33.
- rst_n low at cycle 15 of CALC -> busy=0, done=0, result=0 immediately. A new start after release completes normally.
